mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register for the dual-writeback datapath. Consumes the EX/MEM register outputs (ALU result, effective address, 8-bit store data, rd1/rd2, regWrite1/2, memRd/memWt, flag values and flag-update enables), performs the byte access to the local data memory with a configurable multi-cycle latency, stalls upstream while the access is in flight, and registers everything the writeback stage and register file need.

## Interface
Parameters:
- MEM_LATENCY, 2: extra cycles per data-memory access (0 = single-cycle, max 7)
- MEM_DEPTH_LOG2, 8: data memory is 2^MEM_DEPTH_LOG2 bytes; address uses memAddr[MEM_DEPTH_LOG2-1:0]

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- memRd_in / memWt_in  in  1 each  load / store request from EX/MEM
- memAddr_in  in  32  effective byte address
- storeData_in  in  8  store byte (EX/MEM regrd2)
- aluOut_in  in  32  ALU result
- rd1_in / rd2_in  in  3 each  destination register indices
- regWrite1_in / regWrite2_in  in  1 each  writeback enables
- aluNZCV_in  in  4  ALU flags {N,Z,C,V}; aluFlagEn_in  in  4  per-flag update enables
- memFlagEn_in  in  4  per-flag update enables from the load result
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM; combinational
- wb_aluOut  out  32; wb_memData  out  32  (zero-extended loaded byte)
- wb_rd1 / wb_rd2  out  3 each; wb_regWrite1 / wb_regWrite2  out  1 each
- wb_isLoad  out  1  selects wb_memData over wb_aluOut for port 1
- wb_NZCV  out  4; wb_flagEn  out  4

## Operation
- FSM states IDLE, WAIT. Request = memRd_in | memWt_in.
- IDLE, no request: WB registers capture inputs every cycle; wb_isLoad=0.
- IDLE, request, MEM_LATENCY=0: access completes same cycle; no stall.
- IDLE, request, MEM_LATENCY>0: go WAIT, counter loads MEM_LATENCY-1; stall=1.
- WAIT: counter decrements; stall=1 while in WAIT; on counter==0 return to IDLE next edge, and the request (held stable by upstream) completes in the following IDLE cycle with stall=0.
- While stall=1 WB registers load a bubble: wb_regWrite1/2=0, wb_flagEn=0, wb_isLoad=0; other fields don't-care (hold).
- Completion cycle: store writes storeData_in to memory at that edge; load reads the byte, wb_memData={24'b0,byte}, wb_isLoad=1.
- memRd_in and memWt_in both high: treated as store only; wb_isLoad=0.
- Flags: wb_NZCV=aluNZCV_in, wb_flagEn=aluFlagEn_in, except as modified by MEM_FLAGS_EN.
- Address bits above MEM_DEPTH_LOG2-1 ignored (wrap-around).

## Timing
- Non-memory op: 1-cycle latency input -> wb_* outputs.
- Memory op accepted cycle t: stall high cycles t..t+MEM_LATENCY-1... precisely MEM_LATENCY cycles; completion in cycle t+MEM_LATENCY; wb_* valid in cycle t+MEM_LATENCY+1.
- Back-to-back memory ops: each pays full latency; no overlap.
- Reset (async, any time incl. mid-WAIT): state IDLE, counter 0, stall 0, all wb_* outputs 0. Memory contents not reset; an interrupted store is not performed.

## Configuration
- MEM_FLAGS_EN defined: on a completing load, for each flag with memFlagEn_in set, wb_NZCV takes N=byte[7], Z=(byte==0), C=0, V=0 and wb_flagEn bit is set; load flags override ALU flags bit-by-bit.
- Undefined: memFlagEn_in ignored; flags come from ALU path only.

## Structure
- Shared package/include: state encoding (IDLE=0, WAIT=1), flag bit positions (N=3,Z=2,C=1,V=0), register-index width 3, data width 32.
- One sub-module: data_mem_bytes (2^MEM_DEPTH_LOG2 x 8, synchronous write, combinational read, no reset).

## Test plan
- Reset held low with all inputs driven -> all wb_* = 0, stall = 0; release -> ALU op aluOut_in=0x1234, rd1=3, regWrite1=1 appears on wb_* next cycle.
- Store 0xA5 to addr 0x10, MEM_LATENCY=2 -> stall high exactly 2 cycles, bubble (wb_regWrite1=0) during stall; then load addr 0x10 -> wb_memData=0x000000A5, wb_isLoad=1.
- Address 0x110 with MEM_DEPTH_LOG2=8 -> aliases 0x10; reads 0xA5.
- Reset asserted in WAIT of a store of 0x3C to 0x20 -> state IDLE, stall 0; later load of 0x20 returns prior value, not 0x3C.
- MEM_FLAGS_EN, load of 0x80 with memFlagEn=4'b1100, aluNZCV=4'b0011 -> wb_NZCV=4'b1011, wb_flagEn=4'b1100; without macro wb_NZCV=4'b0011.
- memRd_in and memWt_in both high, data 0x5A at 0x30 -> byte written, wb_isLoad=0; subsequent load returns 0x5A.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the MEM/WB stage: FSM encoding, flag bit positions,
// register-index and data widths, and the writeback bundle.
package mem_wb_stage_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam int REG_W  = 3;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] aluOut;
    logic [DATA_W-1:0] memData;
    logic [REG_W-1:0]  rd1;
    logic [REG_W-1:0]  rd2;
    logic              regWrite1;
    logic              regWrite2;
    logic              isLoad;
    logic [3:0]        nzcv;
    logic [3:0]        flagEn;
  } wb_t;

  function automatic logic [3:0] load_flags(input logic [7:0] b);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = b[7];
    f[FLAG_Z] = (b == 8'd0);
    return f;
  endfunction
endpackage

// File: rtl/data_mem_bytes.sv
// Byte-wide local data memory: synchronous write, combinational read, no reset.
module data_mem_bytes #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);
  logic [7:0] mem_q [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk)
    if (we) mem_q[addr] <= wdata;

  assign rdata = mem_q[addr];
endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB register with multi-cycle data-memory latency.
// Optional MEM_FLAGS_EN: load-result flags override ALU flags per enable bit.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int MEM_LATENCY    = 2,
  parameter int MEM_DEPTH_LOG2 = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRd_in,
  input  logic              memWt_in,
  input  logic [31:0]       memAddr_in,
  input  logic [7:0]        storeData_in,
  input  logic [DATA_W-1:0] aluOut_in,
  input  logic [REG_W-1:0]  rd1_in,
  input  logic [REG_W-1:0]  rd2_in,
  input  logic              regWrite1_in,
  input  logic              regWrite2_in,
  input  logic [3:0]        aluNZCV_in,
  input  logic [3:0]        aluFlagEn_in,
  input  logic [3:0]        memFlagEn_in,
  output logic              stall,
  output logic [DATA_W-1:0] wb_aluOut,
  output logic [DATA_W-1:0] wb_memData,
  output logic [REG_W-1:0]  wb_rd1,
  output logic [REG_W-1:0]  wb_rd2,
  output logic              wb_regWrite1,
  output logic              wb_regWrite2,
  output logic              wb_isLoad,
  output logic [3:0]        wb_NZCV,
  output logic [3:0]        wb_flagEn
);
  localparam logic [2:0] LAT_M1 = (MEM_LATENCY > 0) ? 3'(MEM_LATENCY - 1) : 3'd0;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  wb_t        wb_q, wb_d;
  logic       req, stall_c, complete, is_load, mem_we;
  logic [7:0] rdata;

  assign req     = memRd_in | memWt_in;
  assign is_load = memRd_in & ~memWt_in;

  // done_q marks that the held request has already paid its latency,
  // so the next IDLE cycle completes it instead of restarting the wait.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    stall_c  = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        if (MEM_LATENCY == 0 || done_q) begin
          complete = 1'b1;
          done_d   = 1'b0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = LAT_M1;
          if (LAT_M1 == 3'd0) done_d  = 1'b1;
          else                state_d = WAIT;
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q - 3'd1;
        if (cnt_d == 3'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall  = stall_c & reset;
  assign mem_we = complete & memWt_in & reset;

  data_mem_bytes #(.DEPTH_LOG2(MEM_DEPTH_LOG2)) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (memAddr_in[MEM_DEPTH_LOG2-1:0]),
    .wdata (storeData_in),
    .rdata (rdata)
  );

  logic unused_addr_hi;
  assign unused_addr_hi = ^memAddr_in[31:MEM_DEPTH_LOG2];

`ifdef MEM_FLAGS_EN
  logic [3:0] lflags;
  assign lflags = load_flags(rdata);
`else
  logic unused_flag_en;
  assign unused_flag_en = ^memFlagEn_in;
`endif

  always_comb begin
    wb_d = wb_q;
    if (stall_c) begin
      wb_d.regWrite1 = 1'b0;
      wb_d.regWrite2 = 1'b0;
      wb_d.isLoad    = 1'b0;
      wb_d.flagEn    = 4'b0;
    end else begin
      wb_d.aluOut    = aluOut_in;
      wb_d.memData   = {{(DATA_W-8){1'b0}}, rdata};
      wb_d.rd1       = rd1_in;
      wb_d.rd2       = rd2_in;
      wb_d.regWrite1 = regWrite1_in;
      wb_d.regWrite2 = regWrite2_in;
      wb_d.isLoad    = is_load;
      wb_d.nzcv      = aluNZCV_in;
      wb_d.flagEn    = aluFlagEn_in;
`ifdef MEM_FLAGS_EN
      if (is_load)
        for (int i = 0; i < 4; i++)
          if (memFlagEn_in[i]) begin
            wb_d.nzcv[i]   = lflags[i];
            wb_d.flagEn[i] = 1'b1;
          end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      wb_q    <= wb_d;
    end
  end

  assign wb_aluOut    = wb_q.aluOut;
  assign wb_memData   = wb_q.memData;
  assign wb_rd1       = wb_q.rd1;
  assign wb_rd2       = wb_q.rd2;
  assign wb_regWrite1 = wb_q.regWrite1;
  assign wb_regWrite2 = wb_q.regWrite2;
  assign wb_isLoad    = wb_q.isLoad;
  assign wb_NZCV      = wb_q.nzcv;
  assign wb_flagEn    = wb_q.flagEn;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: per-cycle reference model plus literal checks.
module tb_mem_wb_stage;
  localparam int L  = 2;
  localparam int DL = 8;

  logic        clk = 1'b0, reset;
  logic        memRd_in, memWt_in;
  logic [31:0] memAddr_in, aluOut_in;
  logic [7:0]  storeData_in;
  logic [2:0]  rd1_in, rd2_in;
  logic        regWrite1_in, regWrite2_in;
  logic [3:0]  aluNZCV_in, aluFlagEn_in, memFlagEn_in;
  logic        stall;
  logic [31:0] wb_aluOut, wb_memData;
  logic [2:0]  wb_rd1, wb_rd2;
  logic        wb_regWrite1, wb_regWrite2, wb_isLoad;
  logic [3:0]  wb_NZCV, wb_flagEn;

  mem_wb_stage #(.MEM_LATENCY(L), .MEM_DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .memRd_in(memRd_in), .memWt_in(memWt_in),
    .memAddr_in(memAddr_in), .storeData_in(storeData_in), .aluOut_in(aluOut_in),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .regWrite1_in(regWrite1_in), .regWrite2_in(regWrite2_in),
    .aluNZCV_in(aluNZCV_in), .aluFlagEn_in(aluFlagEn_in), .memFlagEn_in(memFlagEn_in),
    .stall(stall), .wb_aluOut(wb_aluOut), .wb_memData(wb_memData), .wb_rd1(wb_rd1),
    .wb_rd2(wb_rd2), .wb_regWrite1(wb_regWrite1), .wb_regWrite2(wb_regWrite2),
    .wb_isLoad(wb_isLoad), .wb_NZCV(wb_NZCV), .wb_flagEn(wb_flagEn)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a request stalls for L cycles, then completes on the next edge.
  logic [7:0]  mmem [0:(1<<DL)-1];
  logic [31:0] e_alu = 0, e_md = 0;
  logic [2:0]  e_rd1 = 0, e_rd2 = 0;
  logic        e_rw1 = 0, e_rw2 = 0, e_ld = 0, e_vld = 1;
  logic [3:0]  e_nzcv = 0, e_fen = 0;
  int          paid = 0;

  always @(negedge clk) begin
    logic       req, es;
    logic [7:0] b;
    chk("wb_regWrite1", {31'b0, wb_regWrite1}, {31'b0, e_rw1});
    chk("wb_regWrite2", {31'b0, wb_regWrite2}, {31'b0, e_rw2});
    chk("wb_isLoad",    {31'b0, wb_isLoad},    {31'b0, e_ld});
    chk("wb_flagEn",    {28'b0, wb_flagEn},    {28'b0, e_fen});
    if (e_vld) begin
      chk("wb_aluOut", wb_aluOut, e_alu);
      chk("wb_rd1",    {29'b0, wb_rd1},  {29'b0, e_rd1});
      chk("wb_rd2",    {29'b0, wb_rd2},  {29'b0, e_rd2});
      chk("wb_NZCV",   {28'b0, wb_NZCV}, {28'b0, e_nzcv});
    end
    if (e_ld) chk("wb_memData", wb_memData, e_md);

    if (!reset) begin
      chk("stall_rst", {31'b0, stall}, 32'd0);
      {e_alu, e_md, e_rd1, e_rd2, e_rw1, e_rw2, e_ld, e_nzcv, e_fen} = '0;
      e_vld = 1'b1;
      paid  = 0;
    end else begin
      req = memRd_in | memWt_in;
      es  = req && (paid < L);
      chk("stall", {31'b0, stall}, {31'b0, es});
      if (es) begin
        paid++;
        e_rw1 = 0; e_rw2 = 0; e_ld = 0; e_fen = 0; e_vld = 0;
      end else begin
        paid   = 0;
        e_vld  = 1;
        e_alu  = aluOut_in;
        e_rd1  = rd1_in;  e_rd2 = rd2_in;
        e_rw1  = regWrite1_in; e_rw2 = regWrite2_in;
        e_nzcv = aluNZCV_in;   e_fen = aluFlagEn_in;
        e_ld   = memRd_in && !memWt_in;
        if (memWt_in) mmem[int'(memAddr_in % (1 << DL))] = storeData_in;
        if (e_ld) begin
          b    = mmem[int'(memAddr_in % (1 << DL))];
          e_md = {24'b0, b};
`ifdef MEM_FLAGS_EN
          if (memFlagEn_in[3]) begin e_nzcv[3] = b[7];        e_fen[3] = 1; end
          if (memFlagEn_in[2]) begin e_nzcv[2] = (b == 8'd0); e_fen[2] = 1; end
          if (memFlagEn_in[1]) begin e_nzcv[1] = 1'b0;        e_fen[1] = 1; end
          if (memFlagEn_in[0]) begin e_nzcv[0] = 1'b0;        e_fen[0] = 1; end
`endif
        end
      end
    end
  end

  task automatic set_in(input logic rd, input logic wt, input logic [31:0] addr,
                        input logic [7:0] sd, input logic [31:0] alu, input logic [2:0] r1,
                        input logic w1, input logic [3:0] nzcv, input logic [3:0] afen,
                        input logic [3:0] mfen);
    memRd_in = rd; memWt_in = wt; memAddr_in = addr; storeData_in = sd;
    aluOut_in = alu; rd1_in = r1; rd2_in = r1 + 3'd1; regWrite1_in = w1;
    regWrite2_in = w1; aluNZCV_in = nzcv; aluFlagEn_in = afen; memFlagEn_in = mfen;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the completion edge.
  task automatic mem_op(input logic rd, input logic wt, input logic [31:0] addr,
                        input logic [7:0] sd, input logic [3:0] nzcv, input logic [3:0] afen,
                        input logic [3:0] mfen, output int stalls);
    set_in(rd, wt, addr, sd, 32'hC0DE_0000 | addr, 3'd5, 1'b1, nzcv, afen, mfen);
    #1;
    stalls = 0;
    while (stall && stalls < 20) begin
      stalls++;
      @(posedge clk); #2;
    end
    if (stalls >= 20) chk("stall_timeout", 32'(stalls), 32'(L));
    @(posedge clk); #1;
  endtask

  initial begin
    int st;
    reset = 1'b0;
    set_in(1'b1, 1'b0, 32'h10, 8'hFF, 32'hDEAD_BEEF, 3'd7, 1'b1, 4'hF, 4'hF, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_aluOut", wb_aluOut, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_wb_regWrite1", {31'b0, wb_regWrite1}, 32'd0);
    reset = 1'b1;
    set_in(1'b0, 1'b0, 32'h0, 8'h0, 32'h1234, 3'd3, 1'b1, 4'b0100, 4'b0100, 4'b0);
    @(posedge clk); #1;
    chk("alu_aluOut", wb_aluOut, 32'h1234);
    chk("alu_rd1", {29'b0, wb_rd1}, 32'd3);
    chk("alu_rw1", {31'b0, wb_regWrite1}, 32'd1);

    mem_op(1'b0, 1'b1, 32'h10, 8'hA5, 4'b0, 4'b0, 4'b0, st);
    chk("store_stall_cycles", 32'(st), 32'd2);
    mem_op(1'b1, 1'b0, 32'h10, 8'h00, 4'b0, 4'b0, 4'b0, st);
    chk("load_memData", wb_memData, 32'h0000_00A5);
    chk("load_isLoad", {31'b0, wb_isLoad}, 32'd1);
    chk("load_stall_cycles", 32'(st), 32'd2);
    mem_op(1'b1, 1'b0, 32'h110, 8'h00, 4'b0, 4'b0, 4'b0, st);
    chk("alias_memData", wb_memData, 32'h0000_00A5);

    mem_op(1'b0, 1'b1, 32'h20, 8'h77, 4'b0, 4'b0, 4'b0, st);
    set_in(1'b0, 1'b1, 32'h20, 8'h3C, 32'h0, 3'd1, 1'b1, 4'b0, 4'b0, 4'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midwait_rst_stall", {31'b0, stall}, 32'd0);
    chk("midwait_rst_rw1", {31'b0, wb_regWrite1}, 32'd0);
    set_in(1'b0, 1'b0, 32'h0, 8'h0, 32'h0, 3'd0, 1'b0, 4'b0, 4'b0, 4'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    mem_op(1'b1, 1'b0, 32'h20, 8'h00, 4'b0, 4'b0, 4'b0, st);
    chk("interrupted_store", wb_memData, 32'h0000_0077);

    mem_op(1'b0, 1'b1, 32'h40, 8'h80, 4'b0, 4'b0, 4'b0, st);
    mem_op(1'b1, 1'b0, 32'h40, 8'h00, 4'b0011, 4'b0000, 4'b1100, st);
    chk("flag_memData", wb_memData, 32'h0000_0080);
`ifdef MEM_FLAGS_EN
    chk("flag_NZCV", {28'b0, wb_NZCV}, 32'b1011);
    chk("flag_flagEn", {28'b0, wb_flagEn}, 32'b1100);
`else
    chk("flag_NZCV", {28'b0, wb_NZCV}, 32'b0011);
    chk("flag_flagEn", {28'b0, wb_flagEn}, 32'b0000);
`endif

    mem_op(1'b1, 1'b1, 32'h30, 8'h5A, 4'b0, 4'b0, 4'b0, st);
    chk("both_isLoad", {31'b0, wb_isLoad}, 32'd0);
    mem_op(1'b1, 1'b0, 32'h30, 8'h00, 4'b0, 4'b0, 4'b0, st);
    chk("both_readback", wb_memData, 32'h0000_005A);

    set_in(1'b0, 1'b0, 32'h0, 8'h0, 32'hFFFF_0001, 3'd6, 1'b1, 4'b1001, 4'b1111, 4'b1111);
    @(posedge clk); #1;
    chk("alu2_aluOut", wb_aluOut, 32'hFFFF_0001);
    set_in(1'b0, 1'b0, 32'h0, 8'h0, 32'h0, 3'd0, 1'b0, 4'b0, 4'b0, 4'b0);
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
